regfile_multiport: RTL

- Parametrised general-purpose register file for the single-cycle and pipelined CPU datapaths.
- Configurable data width, depth and number of read ports.
- Optional hardwired zero register.
- Synchronous clear, write-first read bypass, and a per-register busy scoreboard so the issue stage can detect read-after-write hazards.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_multiport_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 74 +++++++
 rtl/regfile_multiport.sv | 73 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Helpers work on max-sized vectors; callers zero-extend inputs and truncate results.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    // Upper bounds for the helpers: up to 4 ports of 64 bits, up to 256 entries.
    localparam int unsigned MAX_BUS_W   = 256;
    localparam int unsigned MAX_FIELD_W = 64;
    localparam int unsigned MAX_DEPTH   = 256;

    function automatic logic [MAX_FIELD_W-1:0] get_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        return MAX_FIELD_W'(bus >> (idx * width));
    endfunction

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] vec);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            n += {31'b0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle between the issue/execute logic (master) and the register file (slave).
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD = 2
);

    logic                       enable_write;
    logic [ADDR_W-1:0]          wr;
    logic signed [DATA_W-1:0]   write_data;
    logic [NUM_RD*ADDR_W-1:0]   rr;
    logic [NUM_RD*DATA_W-1:0]   rd;
    logic                       issue_valid;
    logic [ADDR_W-1:0]          issue_reg;
    logic [NUM_RD-1:0]          rd_busy;
    logic [ADDR_W:0]            busy_count;

    modport master (
        output enable_write, wr, write_data, rr, issue_valid, issue_reg,
        input  rd, rd_busy, busy_count
    );

    modport slave (
        input  enable_write, wr, write_data, rr, issue_valid, issue_reg,
        output rd, rd_busy, busy_count
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for RAW hazard detection: busy vector,
// per-port registered busy lookup and registered busy population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_write_i,
    input  logic [ADDR_W-1:0]         wr_i,
    input  logic                      issue_valid_i,
    input  logic [ADDR_W-1:0]         issue_reg_i,
    input  logic [NUM_RD*ADDR_W-1:0]  rr_i,
    output logic [NUM_RD-1:0]         rd_busy_o,
    output logic [ADDR_W:0]           busy_count_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Write clears first, then issue sets, so a same-cycle issue to the
    // register being written leaves the new producer marked in flight.
    always_comb begin
        busy_d = busy_q;
        if (enable_write_i) begin
            busy_d[wr_i] = 1'b0;
        end
        if (issue_valid_i && !(ZERO_REG && issue_reg_i == '0)) begin
            busy_d[issue_reg_i] = 1'b1;
        end
    end

    always_comb begin
        count_d = CNT_W'(popcount(MAX_DEPTH'(busy_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count_o = count_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              busy_bit_q;

        assign addr = ADDR_W'(get_field(MAX_BUS_W'(rr_i), g, ADDR_W));

        // Looking up the next-state vector keeps the flag aligned with the
        // bypassed read data returned in the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                busy_bit_q <= 1'b0;
            end else begin
                busy_bit_q <= busy_d[addr];
            end
        end

        assign rd_busy_o[g] = busy_bit_q;
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with write-first bypass,
// optional hardwired zero register and a busy scoreboard.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                clk,
    input logic                rst,
    regfile_multiport_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

    assign wr_en = bus.enable_write && !(ZERO_REG && bus.wr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[bus.wr] <= bus.write_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_d, data_q;

        assign addr = ADDR_W'(get_field(MAX_BUS_W'(bus.rr), g, ADDR_W));

        always_comb begin
            data_d = mem_q[addr];
            if (ZERO_REG && addr == '0) begin
                data_d = '0;
            end else if (bus.enable_write && bus.wr == addr) begin
                data_d = bus.write_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign bus.rd[g*DATA_W +: DATA_W] = data_q;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .enable_write_i (bus.enable_write),
        .wr_i           (bus.wr),
        .issue_valid_i  (bus.issue_valid),
        .issue_reg_i    (bus.issue_reg),
        .rr_i           (bus.rr),
        .rd_busy_o      (bus.rd_busy),
        .busy_count_o   (bus.busy_count)
    );

endmodule
